chain_host_driver: RTL and testbench

//   Host-side initiator for the matrix chain multiplier (MCM) top level.
//   - Buffers the dimension vector p0..pN-1 from an upstream valid/ready stream.
//   - Replays the vector into the MCM load port, then waits for computation.
//   - Sweeps the upper-triangular solution table (i<=j) through the MCM read port.
//   - Returns each cost to the host as a tagged valid/ready result stream.

---
 rtl/chain_host_driver.sv | 142 ++++++++++++++
 tb/tb_chain_host_driver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_host_driver.sv
// chain_host_driver: buffers a dimension vector, loads it into the MCM, waits for
// the computation, then streams the upper-triangular cost table back to the host.
module chain_host_driver #(
    parameter int MAX_DIMS     = 32,
    parameter int DATA_W       = 8,
    parameter int RES_W        = 32,
    parameter int COMPUTE_WAIT = 512,
    parameter int READ_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dim_valid,
    output logic              dim_ready,
    input  logic [DATA_W-1:0] dim_data,
    input  logic              dim_last,
    output logic [DATA_W-1:0] mcm_mdata,
    output logic              mcm_data_in,
    output logic [DATA_W-1:0] mcm_i,
    output logic [DATA_W-1:0] mcm_j,
    output logic              mcm_out,
    input  logic [RES_W-1:0]  mcm_dout,
    input  logic [DATA_W-1:0] mcm_matlen,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [DATA_W-1:0] res_i,
    output logic [DATA_W-1:0] res_j,
    output logic              res_last,
    output logic              busy,
    output logic              err
);
    localparam int CW = $clog2(MAX_DIMS + 1);
    localparam int IW = $clog2(MAX_DIMS);
    localparam int KW = $clog2(COMPUTE_WAIT + MAX_DIMS + READ_LAT + 2);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, READ, RESP} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] dims [MAX_DIMS];
    logic [CW-1:0]     cnt, n, n_new;
    logic [IW-1:0]     i, j, last_idx;
    logic [KW-1:0]     k;
    logic              acc, full, last_res;

    assign acc      = state == IDLE && dim_valid;
    assign full     = cnt == CW'(MAX_DIMS);
    assign n_new    = full ? CW'(MAX_DIMS) : cnt + CW'(1);
    assign last_idx = IW'(n - CW'(2));
    assign last_res = i == last_idx && j == last_idx;
    assign mcm_i    = DATA_W'(i);
    assign mcm_j    = DATA_W'(j);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        dim_ready   = 1'b0;
        busy        = 1'b1;
        mcm_data_in = 1'b0;
        mcm_mdata   = '0;
        mcm_out     = 1'b0;
        res_valid   = 1'b0;
        res_last    = 1'b0;
        case (state)
            IDLE: begin
                dim_ready = 1'b1;
                busy      = 1'b0;
                if (acc && dim_last && n_new >= CW'(2)) state_nx = LOAD;
            end
            LOAD: begin
                mcm_data_in = 1'b1;
                mcm_mdata   = dims[k[IW-1:0]];
                if (k == KW'(n - CW'(1))) state_nx = WAIT;
            end
            WAIT: if (k == KW'(COMPUTE_WAIT - 1)) state_nx = READ;
            READ: begin
                mcm_out = k == '0;
                if (k == KW'(READ_LAT)) state_nx = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                res_last  = last_res;
                if (res_ready) state_nx = last_res ? IDLE : READ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc && !full) dims[cnt[IW-1:0]] <= dim_data;
    end

    // k is shared: load index, compute-wait timer, and read-latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            n        <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            err      <= 1'b0;
            res_data <= '0;
            res_i    <= '0;
            res_j    <= '0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    if (full) err <= 1'b1;
                    if (dim_last) begin
                        cnt <= '0;
                        n   <= n_new;
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        if (n_new < CW'(2)) err <= 1'b1;
                    end else if (!full) cnt <= cnt + CW'(1);
                end
                LOAD: k <= k == KW'(n - CW'(1)) ? '0 : k + KW'(1);
                WAIT: begin
                    if (k == '0 && mcm_matlen != DATA_W'(n)) err <= 1'b1;
                    k <= k == KW'(COMPUTE_WAIT - 1) ? '0 : k + KW'(1);
                end
                READ: if (k == KW'(READ_LAT)) begin
                    k        <= '0;
                    res_data <= mcm_dout;
                    res_i    <= DATA_W'(i);
                    res_j    <= DATA_W'(j);
                end else k <= k + KW'(1);
                RESP: if (res_ready) begin
                    if (j == last_idx) begin
                        i <= i + IW'(1);
                        j <= i + IW'(1);
                    end else j <= j + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chain_host_driver.sv
// tb_chain_host_driver: randomized runs against a triangle-sweep reference model
// with a behavioural MCM returning m[i][j] = i*256 + j.
module tb_chain_host_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dim_valid = 1'b0;
    logic        dim_ready;
    logic [7:0]  dim_data = '0;
    logic        dim_last = 1'b0;
    logic [7:0]  mcm_mdata;
    logic        mcm_data_in;
    logic [7:0]  mcm_i, mcm_j;
    logic        mcm_out;
    logic [31:0] mcm_dout = '0;
    logic [7:0]  mcm_matlen = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [7:0]  res_i, res_j;
    logic        res_last;
    logic        busy;
    logic        err;

    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    logic [7:0] load_q[$];
    int         vals[40];

    chain_host_driver dut (
        .clk(clk), .rst(rst), .dim_valid(dim_valid), .dim_ready(dim_ready),
        .dim_data(dim_data), .dim_last(dim_last), .mcm_mdata(mcm_mdata),
        .mcm_data_in(mcm_data_in), .mcm_i(mcm_i), .mcm_j(mcm_j), .mcm_out(mcm_out),
        .mcm_dout(mcm_dout), .mcm_matlen(mcm_matlen), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_i(res_i), .res_j(res_j),
        .res_last(res_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural MCM read port: one-cycle latency from strobe to data
    always @(posedge clk) if (mcm_out) mcm_dout <= 32'(mcm_i) * 256 + 32'(mcm_j);

    always @(negedge clk) begin
        if (mcm_data_in) load_q.push_back(mcm_mdata);
        if (mcm_out) pulses++;
    end

    task automatic do_reset();
        rst = 1'b1;
        dim_valid = 1'b0;
        dim_last = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load_q.delete();
        pulses = 0;
    endtask

    task automatic send_words(input int len);
        for (int w = 0; w < len; w++) begin
            dim_valid = 1'b1;
            dim_data = 8'(vals[w]);
            dim_last = w == len - 1;
            @(negedge clk);
        end
        dim_valid = 1'b0;
        dim_last = 1'b0;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        int cyc = 0;
        while (!res_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        ok = res_valid;
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL %s: res_valid timeout, got 0 need 1", name);
        end
    endtask

    task automatic run_case(input string name, input int len, input bit mism, input bit exp_err);
        int n;
        bit ok;
        int exp_pulses;
        do_reset();
        n = len > 32 ? 32 : len;
        mcm_matlen = 8'(mism ? n - 1 : n);
        send_words(len);
        for (int a = 0; a < n - 1; a++) begin
            for (int b = a; b < n - 1; b++) begin
                wait_valid(name, ok);
                if (!ok) return;
                checks++;
                if (res_i !== 8'(a) || res_j !== 8'(b) || res_data !== 32'(a * 256 + b)
                    || res_last !== (a == n - 2 && b == n - 2)) begin
                    errors++;
                    $display("FAIL %s result: got (%0d,%0d)=%0d last=%b need (%0d,%0d)=%0d last=%b",
                             name, res_i, res_j, res_data, res_last, a, b, a * 256 + b,
                             a == n - 2 && b == n - 2);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                res_ready = 1'b1;
                @(negedge clk);
                res_ready = 1'b0;
            end
        end
        exp_pulses = n * (n - 1) / 2;
        checks++;
        if (busy !== 1'b0 || dim_ready !== 1'b1 || pulses != exp_pulses) begin
            errors++;
            $display("FAIL %s end: busy=%b ready=%b pulses=%0d need 0 1 %0d",
                     name, busy, dim_ready, pulses, exp_pulses);
        end
        checks++;
        if (load_q.size() != n) begin
            errors++;
            $display("FAIL %s load_len: got %0d need %0d", name, load_q.size(), n);
        end else begin
            for (int w = 0; w < n; w++) begin
                checks++;
                if (load_q[w] !== 8'(vals[w])) begin
                    errors++;
                    $display("FAIL %s load[%0d]: got %0d need %0d", name, w, load_q[w], vals[w]);
                end
            end
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err: got %b need %b", name, err, exp_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({dim_ready, busy, err, res_valid, mcm_out, mcm_data_in, res_last} !== 7'b1000000
            || mcm_mdata !== 8'd0 || mcm_i !== 8'd0 || mcm_j !== 8'd0 || res_data !== 32'd0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b err=%b valid=%b out=%b din=%b need 1 0 0 0 0 0",
                     dim_ready, busy, err, res_valid, mcm_out, mcm_data_in);
        end
    endtask

    task automatic test_dims3();
        vals[0] = 10; vals[1] = 20; vals[2] = 30;
        run_case("dims3", 3, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int len = $urandom_range(2, 9);
            for (int w = 0; w < len; w++) vals[w] = $urandom_range(1, 255);
            run_case("random", len, 1'b0, 1'b0);
        end
    endtask

    task automatic test_mismatch();
        for (int w = 0; w < 6; w++) vals[w] = $urandom_range(1, 255);
        run_case("mismatch", 6, 1'b1, 1'b1);
    endtask

    task automatic test_overflow();
        for (int w = 0; w < 33; w++) vals[w] = $urandom_range(1, 255);
        run_case("overflow", 33, 1'b0, 1'b1);
    endtask

    task automatic test_single();
        do_reset();
        vals[0] = 7;
        mcm_matlen = 8'd1;
        send_words(1);
        repeat (10) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || dim_ready !== 1'b1 || load_q.size() != 0) begin
            errors++;
            $display("FAIL single: err=%b busy=%b ready=%b loads=%0d need 1 0 1 0",
                     err, busy, dim_ready, load_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] d;
        logic [7:0] si, sj;
        int p;
        do_reset();
        vals[0] = 10; vals[1] = 20; vals[2] = 30;
        mcm_matlen = 8'd3;
        send_words(3);
        wait_valid("stall", ok);
        if (!ok) return;
        d = res_data; si = res_i; sj = res_j; p = pulses;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== d || res_i !== si || res_j !== sj || pulses != p) begin
                errors++;
                $display("FAIL stall cyc %0d: valid=%b data=%0d i=%0d j=%0d pulses=%0d need 1 %0d %0d %0d %0d",
                         c, res_valid, res_data, res_i, res_j, pulses, d, si, sj, p);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        wait_valid("stall", ok);
        if (!ok) return;
        checks++;
        if (pulses != p + 1 || res_i !== 8'd0 || res_j !== 8'd1 || res_data !== 32'd1) begin
            errors++;
            $display("FAIL stall resume: pulses=%0d (%0d,%0d)=%0d need %0d (0,1)=1",
                     pulses, res_i, res_j, res_data, p + 1);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        do_reset();
        for (int w = 0; w < 4; w++) vals[w] = w + 3;
        mcm_matlen = 8'd4;
        send_words(4);
        while (!mcm_out && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cyc >= 3000 || mcm_out !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || dim_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: cyc=%0d out=%b valid=%b busy=%b ready=%b need out 0 0 0 1",
                     cyc, mcm_out, res_valid, busy, dim_ready);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dims3();
        test_stall();
        test_random();
        test_mismatch();
        test_single();
        test_reset_mid();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
